// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake LED-matrix renderer.
package snake_pkg;

  localparam int N_DEF = 4;
  localparam int MAXB = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    BUILD = 1'b1
  } state_t;

  // One spare code above N*N so out-of-range indices are representable.
  function automatic int cell_w(input int n);
    return $clog2(n * n + 1);
  endfunction

  function automatic logic [MAXB-1:0] border_mask(input int w);
    logic [MAXB-1:0] m;
    m = '0;
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        if (r == 0 || c == 0 || r == w - 1 || c == w - 1)
          m[r*w+c] = 1'b1;
    return m;
  endfunction

  function automatic int cell_to_led(input int pos, input int n);
    return (pos / n + 1) * (n + 2) + (pos % n) + 1;
  endfunction

endpackage

// File: rtl/snake_matrix_render_scan.sv
// Row-multiplexed scan of a WxW bitmap: one-hot row select plus
// the matching column bits, registered together.
module matrix_scan #(
  parameter int W   = 6,
  parameter int DIV = 1000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [W*W-1:0] bitmap,
  output logic [W-1:0]   row_sel,
  output logic [W-1:0]   col_data
);

  localparam int RW = (W > 1) ? $clog2(W) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
  localparam logic [RW-1:0] RLAST = RW'(W - 1);

  logic [DW-1:0] cnt;
  logic [RW-1:0] row;
  logic [RW-1:0] row_nx;
  logic          wrap;

  assign wrap = (cnt == DLAST);

  always_comb begin
    row_nx = row;
    if (wrap)
      row_nx = (row == RLAST) ? '0 : row + RW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      row      <= '0;
      row_sel  <= W'(1);
      col_data <= '1;
    end else begin
      cnt      <= wrap ? '0 : cnt + DW'(1);
      row      <= row_nx;
      row_sel  <= W'(1) << row_nx;
      col_data <= W'(bitmap >> (int'(row_nx) * W));
    end
  end

endmodule

// File: rtl/snake_matrix_render.sv
// Snake LED-matrix renderer: back/front buffers with border,
// blinking apple overlay and row scan output.
module snake_matrix_render
  import snake_pkg::*;
#(
  parameter  int N         = N_DEF,
  parameter  int SCAN_DIV  = 1000,
  parameter  int BLINK_DIV = 25000000,
  localparam int PW        = cell_w(N),
  localparam int W         = N + 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           frame_start,
  input  logic           cell_valid,
  input  logic [PW-1:0]  cell_pos,
  output logic           cell_ready,
  input  logic           frame_commit,
  input  logic [PW-1:0]  apple_pos,
  input  logic           apple_en,
  output logic           frame_done,
  output logic           range_err,
  output logic [W*W-1:0] leds,
  output logic [W-1:0]   row_sel,
  output logic [W-1:0]   col_data
);

  localparam int WW = W * W;
  localparam int NN = N * N;
  localparam logic [PW-1:0] NN_L = PW'(NN);
  localparam logic [MAXB-1:0] BFULL = border_mask(W);
  localparam logic [WW-1:0] BORDER = BFULL[WW-1:0];
  localparam logic [WW-1:0] ONE = WW'(1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLAST = BW'(BLINK_DIV - 1);

  state_t        state;
  logic [WW-1:0] back;
  logic [WW-1:0] front;
  logic [WW-1:0] back_nx;
  logic [WW-1:0] apple_mask;
  logic [WW-1:0] apple_nx;
  logic [BW-1:0] bcnt;
  logic          blink;
  logic          pos_ok;
  logic          apple_ok;

  assign pos_ok     = (cell_pos < NN_L);
  assign apple_ok   = (apple_pos < NN_L);
  assign cell_ready = (state == BUILD);

  always_comb begin
    back_nx = back;
    if (cell_valid && pos_ok)
      back_nx = back | (ONE << cell_to_led(int'(cell_pos), N));
  end

  always_comb begin
    apple_nx = '0;
    if (apple_en && apple_ok)
      apple_nx = ONE << cell_to_led(int'(apple_pos), N);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      back       <= BORDER;
      front      <= BORDER;
      apple_mask <= '0;
      frame_done <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        back      <= BORDER;
        range_err <= 1'b0;
        state     <= BUILD;
      end else if (state == BUILD) begin
        back <= back_nx;
        if (cell_valid && !pos_ok)
          range_err <= 1'b1;
        // The same-cycle cell write lands in the committed frame too.
        if (frame_commit) begin
          front      <= back_nx;
          apple_mask <= apple_nx;
          state      <= IDLE;
          frame_done <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bcnt  <= '0;
      blink <= 1'b1;
    end else if (bcnt == BLAST) begin
      bcnt  <= '0;
      blink <= ~blink;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  // An apple on a snake cell stays lit because front already has it.
  assign leds = front | (blink ? apple_mask : '0);

  matrix_scan #(
    .W   (W),
    .DIV (SCAN_DIV)
  ) u_scan (
    .clock    (clock),
    .reset    (reset),
    .bitmap   (leds),
    .row_sel  (row_sel),
    .col_data (col_data)
  );

endmodule

// File: tb/tb_snake_matrix_render.sv
// Directed self-checking bench for snake_matrix_render
// (N=4, SCAN_DIV=2, BLINK_DIV=4).
module tb_snake_matrix_render;

  localparam logic [35:0] BORDER = 36'hFE186187F;

  logic        clock;
  logic        reset;
  logic        frame_start;
  logic        cell_valid;
  logic [4:0]  cell_pos;
  logic        cell_ready;
  logic        frame_commit;
  logic [4:0]  apple_pos;
  logic        apple_en;
  logic        frame_done;
  logic        range_err;
  logic [35:0] leds;
  logic [5:0]  row_sel;
  logic [5:0]  col_data;

  int tests = 0;
  int fails = 0;

  logic [1:0] bcnt_m;
  logic       bph_m;
  logic       scnt_m;
  int         srow_m;

  snake_matrix_render #(
    .N         (4),
    .SCAN_DIV  (2),
    .BLINK_DIV (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .cell_valid   (cell_valid),
    .cell_pos     (cell_pos),
    .cell_ready   (cell_ready),
    .frame_commit (frame_commit),
    .apple_pos    (apple_pos),
    .apple_en     (apple_en),
    .frame_done   (frame_done),
    .range_err    (range_err),
    .leds         (leds),
    .row_sel      (row_sel),
    .col_data     (col_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference blink phase and scan row.
  always @(posedge clock) begin
    if (reset) begin
      bcnt_m <= 2'd0;
      bph_m  <= 1'b1;
      scnt_m <= 1'b0;
      srow_m <= 0;
    end else begin
      if (bcnt_m == 2'd3) begin
        bcnt_m <= 2'd0;
        bph_m  <= ~bph_m;
      end else begin
        bcnt_m <= bcnt_m + 2'd1;
      end
      if (scnt_m) begin
        scnt_m <= 1'b0;
        srow_m <= (srow_m == 5) ? 0 : srow_m + 1;
      end else begin
        scnt_m <= 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic write_cell(input logic [4:0] p);
    cell_valid = 1'b1;
    cell_pos   = p;
    step();
    cell_valid = 1'b0;
  endtask

  task automatic commit(input logic [4:0] ap, input logic ae);
    apple_pos    = ap;
    apple_en     = ae;
    frame_commit = 1'b1;
    step();
    frame_commit = 1'b0;
    apple_en     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    tests++;
    if (leds !== BORDER) begin
      fails++;
      $display("FAIL reset_leds got %h exp %h", leds, BORDER);
    end
    tests++;
    if (row_sel !== 6'b000001 || col_data !== 6'b111111) begin
      fails++;
      $display("FAIL reset_scan got %b/%b exp 000001/111111", row_sel, col_data);
    end
    tests++;
    if ({cell_ready, frame_done, range_err} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b exp 000", {cell_ready, frame_done, range_err});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_frame();
    logic [35:0] e;
    e = BORDER;
    e[7] = 1'b1;
    e[14] = 1'b1;
    e[28] = 1'b1;
    start_frame();
    tests++;
    if (cell_ready !== 1'b1) begin
      fails++;
      $display("FAIL build_ready got %b exp 1", cell_ready);
    end
    write_cell(5'd0);
    write_cell(5'd5);
    cell_valid   = 1'b1;
    cell_pos     = 5'd15;
    commit(5'd0, 1'b0);
    cell_valid   = 1'b0;
    tests++;
    if (frame_done !== 1'b1 || cell_ready !== 1'b0) begin
      fails++;
      $display("FAIL commit_done got %b/%b exp 1/0", frame_done, cell_ready);
    end
    tests++;
    if (leds !== e) begin
      fails++;
      $display("FAIL frame1_leds got %h exp %h", leds, e);
    end
    step();
    tests++;
    if (frame_done !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse got %b exp 0", frame_done);
    end
  endtask

  task automatic test_second_frame();
    logic [35:0] e;
    e = BORDER;
    e[15] = 1'b1;
    start_frame();
    write_cell(5'd6);
    commit(5'd0, 1'b0);
    tests++;
    if (leds !== e) begin
      fails++;
      $display("FAIL frame2_leds got %h exp %h", leds, e);
    end
    commit(5'd0, 1'b0);
    tests++;
    if (frame_done !== 1'b0 || leds !== e) begin
      fails++;
      $display("FAIL idle_commit got %b/%h exp 0/%h", frame_done, leds, e);
    end
  endtask

  task automatic test_range();
    start_frame();
    write_cell(5'd20);
    tests++;
    if (range_err !== 1'b1) begin
      fails++;
      $display("FAIL range_set got %b exp 1", range_err);
    end
    commit(5'd0, 1'b0);
    tests++;
    if (leds !== BORDER) begin
      fails++;
      $display("FAIL range_nowrite got %h exp %h", leds, BORDER);
    end
    start_frame();
    tests++;
    if (range_err !== 1'b0) begin
      fails++;
      $display("FAIL range_clear got %b exp 0", range_err);
    end
    commit(5'd0, 1'b0);
    write_cell(5'd20);
    tests++;
    if (range_err !== 1'b0 || leds !== BORDER) begin
      fails++;
      $display("FAIL idle_write got %b/%h exp 0/%h", range_err, leds, BORDER);
    end
  endtask

  task automatic test_apple();
    logic [35:0] e;
    start_frame();
    commit(5'd3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      e = BORDER;
      e[10] = bph_m;
      tests++;
      if (leds !== e) begin
        fails++;
        $display("FAIL apple_blink got %h exp %h", leds, e);
      end
      step();
    end
    start_frame();
    cell_valid = 1'b1;
    cell_pos   = 5'd3;
    commit(5'd3, 1'b1);
    cell_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (leds[10] !== 1'b1) begin
        fails++;
        $display("FAIL apple_on_snake got %b exp 1", leds[10]);
      end
      step();
    end
    start_frame();
    commit(5'd16, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (leds !== BORDER) begin
        fails++;
        $display("FAIL apple_range got %h exp %h", leds, BORDER);
      end
      step();
    end
  endtask

  task automatic test_scan();
    logic [35:0] e;
    logic [5:0]  er;
    e = BORDER;
    e[7] = 1'b1;
    e[14] = 1'b1;
    e[28] = 1'b1;
    start_frame();
    write_cell(5'd0);
    write_cell(5'd5);
    write_cell(5'd15);
    commit(5'd0, 1'b0);
    step();
    for (int i = 0; i < 16; i++) begin
      er = 6'd1 << srow_m;
      tests++;
      if (row_sel !== er) begin
        fails++;
        $display("FAIL scan_row got %b exp %b", row_sel, er);
      end
      tests++;
      if (col_data !== e[srow_m*6 +: 6]) begin
        fails++;
        $display("FAIL scan_col got %b exp %b", col_data, e[srow_m*6 +: 6]);
      end
      step();
    end
  endtask

  task automatic test_start_commit();
    logic [35:0] e;
    e = BORDER;
    e[7] = 1'b1;
    e[14] = 1'b1;
    e[28] = 1'b1;
    frame_start  = 1'b1;
    frame_commit = 1'b1;
    step();
    frame_start  = 1'b0;
    frame_commit = 1'b0;
    tests++;
    if (frame_done !== 1'b0 || cell_ready !== 1'b1) begin
      fails++;
      $display("FAIL start_wins got %b/%b exp 0/1", frame_done, cell_ready);
    end
    step();
    tests++;
    if (frame_done !== 1'b0 || leds !== e) begin
      fails++;
      $display("FAIL start_wins_leds got %b/%h exp 0/%h", frame_done, leds, e);
    end
    commit(5'd0, 1'b0);
    tests++;
    if (frame_done !== 1'b1 || leds !== BORDER) begin
      fails++;
      $display("FAIL after_start_commit got %b/%h exp 1/%h", frame_done, leds, BORDER);
    end
  endtask

  task automatic test_reset_mid();
    start_frame();
    write_cell(5'd6);
    commit(5'd0, 1'b0);
    start_frame();
    write_cell(5'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (leds !== BORDER || cell_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid got %h/%b exp %h/0", leds, cell_ready, BORDER);
    end
    commit(5'd0, 1'b0);
    tests++;
    if (frame_done !== 1'b0 || leds !== BORDER) begin
      fails++;
      $display("FAIL reset_mid_commit got %b/%h exp 0/%h", frame_done, leds, BORDER);
    end
  endtask

  initial begin
    reset        = 1'b1;
    frame_start  = 1'b0;
    cell_valid   = 1'b0;
    cell_pos     = 5'd0;
    frame_commit = 1'b0;
    apple_pos    = 5'd0;
    apple_en     = 1'b0;
    test_reset();
    test_frame();
    test_second_frame();
    test_range();
    test_apple();
    test_scan();
    test_start_commit();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
